// File: rtl/wrr_sched_pkg.sv
// Shared types for the weighted round-robin scheduler: lock state and mode encodings.
package wrr_sched_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    localparam int MODE_RR  = 0;
    localparam int MODE_WRR = 1;

endpackage

// File: rtl/find_first_set.sv
// Reports the lowest-index set bit of a vector and whether any bit is set.
module find_first_set #(
    parameter  int W  = 4,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = |vec;
        idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/wrr_sched.sv
// Packet-aware round-robin / weighted round-robin arbiter with a zero-cycle grant
// and valid/ready handshake; a granted requester keeps the grant until its last beat.
module wrr_sched
    import wrr_sched_pkg::*;
#(
    parameter  int LG_N   = 2,
    parameter  int W_BITS = 3,
    parameter  int MODE   = 1,
    localparam int N      = 1 << LG_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        last,
    input  logic [N*W_BITS-1:0] weight,
    input  logic                gnt_ready,
    output logic                gnt_valid,
    output logic [LG_N-1:0]     gnt_id,
    output logic [N-1:0]        gnt_onehot
);

    lock_state_e       state_q, state_d;
    logic [LG_N-1:0]   lock_id_q, lock_id_d;
    logic [LG_N-1:0]   ptr_q, ptr_d;
    logic [W_BITS-1:0] cred_q, cred_d;

    logic [2*N-1:0]    req_dbl;
    logic [N-1:0]      req_rot;
    logic              arb_found;
    logic [LG_N-1:0]   arb_off;
    logic [LG_N-1:0]   arb_id;
    logic [LG_N-1:0]   sel_id;
    logic              accept;
    logic [W_BITS-1:0] wt_arr [N];
    logic [W_BITS-1:0] cred_sel;

    // Rotating the doubled vector puts the current pointer at bit 0.
    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> ptr_q);

    find_first_set #(.W(N)) u_ffs (
        .vec   (req_rot),
        .found (arb_found),
        .idx   (arb_off)
    );

    assign arb_id = ptr_q + arb_off;

    always_comb begin
        sel_id    = arb_id;
        gnt_valid = arb_found;
        if (state_q == LOCKED) begin
            sel_id    = lock_id_q;
            gnt_valid = req[lock_id_q];
        end
        gnt_id = gnt_valid ? sel_id : '0;
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign gnt_onehot[gi] = gnt_valid && (gnt_id == LG_N'(gi));
            // A zero weight behaves as a weight of one.
            assign wt_arr[gi] = (weight[gi*W_BITS +: W_BITS] == '0)
                                ? W_BITS'(1) : weight[gi*W_BITS +: W_BITS];
        end
    endgenerate

    assign accept   = gnt_valid & gnt_ready;
    // Leftover credit only applies when the packet belongs to the requester that earned it.
    assign cred_sel = ((gnt_id == ptr_q) && (cred_q != '0)) ? cred_q : wt_arr[gnt_id];

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        ptr_d     = ptr_q;
        cred_d    = cred_q;
        if (accept) begin
            if (last[gnt_id]) begin
                state_d = UNLOCKED;
                if (MODE == MODE_WRR && cred_sel > W_BITS'(1)) begin
                    ptr_d  = gnt_id;
                    cred_d = cred_sel - W_BITS'(1);
                end else begin
                    ptr_d  = gnt_id + LG_N'(1);
                    cred_d = '0;
                end
            end else begin
                state_d   = LOCKED;
                lock_id_d = gnt_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNLOCKED;
            lock_id_q <= '0;
            ptr_q     <= '0;
            cred_q    <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            ptr_q     <= ptr_d;
            cred_q    <= cred_d;
        end
    end

    // Simulation guard: a grant must never go to an idle requester.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((gnt_onehot & ~req) == '0) else $stop;
        end
    end

endmodule
